// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's memory access bundle (request, grant, tagged read return).
interface dmem_arbiter_if #(parameter int ADDR_W = 12, parameter int DATA_W = 32);
  logic req;
  logic wren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic gnt;
  logic rvalid;
  logic [DATA_W-1:0] q;
  modport master(output req, wren, addr, data, input gnt, rvalid, q);
  modport slave(input req, wren, addr, data, output gnt, rvalid, q);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between CPU and VGA; VGA priority with CPU anti-starvation.
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int READ_LAT = 1,
  parameter int STARVE_MAX = 8
) (
  input logic clock,
  input logic resetn,
  dmem_arbiter_if.slave cpu,
  dmem_arbiter_if.slave vga,
  output logic cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic mem_wren,
  input logic [DATA_W-1:0] mem_q
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic {NORMAL, FORCE} state_t;
  state_t state;
  logic [CW-1:0] starve_cnt;
  logic [READ_LAT-1:0] tag_vld;
  logic [READ_LAT-1:0] tag_own;
  logic force_cpu;
  assign force_cpu = state == FORCE;
  always_comb begin
    cpu.gnt = resetn & cpu.req & (force_cpu | ~vga.req);
    vga.gnt = resetn & vga.req & ~(force_cpu & cpu.req);
    cpu_stall = cpu.req & ~cpu.gnt;
    mem_addr = cpu.gnt ? cpu.addr : vga.gnt ? vga.addr : '0;
    mem_data = cpu.gnt ? cpu.data : vga.gnt ? vga.data : '0;
    mem_wren = cpu.gnt ? cpu.wren : vga.gnt & vga.wren;
    cpu.rvalid = tag_vld[READ_LAT-1] & ~tag_own[READ_LAT-1];
    vga.rvalid = tag_vld[READ_LAT-1] & tag_own[READ_LAT-1];
    cpu.q = cpu.rvalid ? mem_q : '0;
    vga.q = vga.rvalid ? mem_q : '0;
  end
  // tag_own: 1 = VGA owns the read in flight
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= NORMAL;
      starve_cnt <= '0;
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld[0] <= (cpu.gnt & ~cpu.wren) | (vga.gnt & ~vga.wren);
      tag_own[0] <= vga.gnt;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
      if (force_cpu) begin
        state <= NORMAL;
        starve_cnt <= '0;
      end else if (cpu_stall) begin
        starve_cnt <= (starve_cnt == CW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
        if (starve_cnt >= CW'(STARVE_MAX - 1)) state <= FORCE;
      end else begin
        starve_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven vectors plus starvation and reset sequences against a synchronous RAM model.
module tb_dmem_arbiter;
  localparam logic [31:0] C1 = 32'h1111_1111;
  localparam logic [31:0] V2 = 32'h2222_2222;
  typedef struct {
    logic cr, cw; logic [11:0] ca; logic [31:0] cd;
    logic vr, vw; logic [11:0] va; logic [31:0] vd;
    logic ecg, evg; logic [11:0] ea; logic [31:0] ed; logic ew;
    logic ecrv, evrv; logic [31:0] ecq, evq;
  } vec_t;
  logic clock = 0;
  logic resetn = 0;
  logic cpu_stall, mem_wren;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_q = '0;
  logic [31:0] ram [4096];
  int checks = 0;
  int fails = 0;
  vec_t vecs [13];
  dmem_arbiter_if cpu();
  dmem_arbiter_if vga();
  dmem_arbiter dut (
    .clock(clock), .resetn(resetn), .cpu(cpu), .vga(vga), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic cr, input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                       input logic vr, input logic vw, input logic [11:0] va, input logic [31:0] vd);
    cpu.req = cr; cpu.wren = cw; cpu.addr = ca; cpu.data = cd;
    vga.req = vr; vga.wren = vw; vga.addr = va; vga.data = vd;
  endtask
  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    drive(v.cr, v.cw, v.ca, v.cd, v.vr, v.vw, v.va, v.vd);
    #2;
    chk({tag, " cpu_gnt"}, 32'(cpu.gnt), 32'(v.ecg));
    chk({tag, " vga_gnt"}, 32'(vga.gnt), 32'(v.evg));
    chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'(v.cr & ~v.ecg));
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.ea));
    chk({tag, " mem_data"}, mem_data, v.ed);
    chk({tag, " mem_wren"}, 32'(mem_wren), 32'(v.ew));
    chk({tag, " cpu_rvalid"}, 32'(cpu.rvalid), 32'(v.ecrv));
    chk({tag, " vga_rvalid"}, 32'(vga.rvalid), 32'(v.evrv));
    chk({tag, " cpu_q"}, cpu.q, v.ecq);
    chk({tag, " vga_q"}, vga.q, v.evq);
  endtask
  task automatic reset_pulse(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 0;
    @(negedge clock);
    #2;
    chk({tag, " rst cpu_gnt"}, 32'(cpu.gnt), 0);
    chk({tag, " rst vga_gnt"}, 32'(vga.gnt), 0);
    chk({tag, " rst cpu_rvalid"}, 32'(cpu.rvalid), 0);
    chk({tag, " rst vga_rvalid"}, 32'(vga.rvalid), 0);
    chk({tag, " rst cpu_q"}, cpu.q, 0);
    chk({tag, " rst vga_q"}, vga.q, 0);
    chk({tag, " rst mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " rst mem_data"}, mem_data, 0);
    chk({tag, " rst mem_wren"}, 32'(mem_wren), 0);
    resetn = 1;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h100 + 3 * i;
    ram[12'h010] = 32'h0000_00AB;
    vecs[0]  = '{1,0,12'h010,C1, 0,0,12'h000,V2, 1,0,12'h010,C1,0, 0,0,32'h0,32'h0};
    vecs[1]  = '{1,0,12'h020,C1, 1,0,12'h030,V2, 0,1,12'h030,V2,0, 1,0,32'hAB,32'h0};
    vecs[2]  = '{1,0,12'h020,C1, 0,0,12'h000,V2, 1,0,12'h020,C1,0, 0,1,32'h0,32'h190};
    vecs[3]  = '{0,0,12'h000,C1, 1,1,12'h3FF,32'hDEADBEEF, 0,1,12'h3FF,32'hDEADBEEF,1, 1,0,32'h160,32'h0};
    vecs[4]  = '{1,0,12'h3FF,C1, 0,0,12'h000,V2, 1,0,12'h3FF,C1,0, 0,0,32'h0,32'h0};
    vecs[5]  = '{0,0,12'h000,C1, 1,0,12'h040,V2, 0,1,12'h040,V2,0, 1,0,32'hDEADBEEF,32'h0};
    vecs[6]  = '{1,0,12'h050,C1, 0,0,12'h000,V2, 1,0,12'h050,C1,0, 0,1,32'h0,32'h1C0};
    vecs[7]  = '{0,0,12'h000,C1, 1,0,12'h010,V2, 0,1,12'h010,V2,0, 1,0,32'h1F0,32'h0};
    vecs[8]  = '{0,0,12'h000,C1, 0,0,12'h000,V2, 0,0,12'h000,32'h0,0, 0,1,32'h0,32'hAB};
    vecs[9]  = '{1,1,12'h050,32'h12345678, 0,0,12'h000,V2, 1,0,12'h050,32'h12345678,1, 0,0,32'h0,32'h0};
    vecs[10] = '{0,0,12'h000,C1, 1,0,12'h050,V2, 0,1,12'h050,V2,0, 0,0,32'h0,32'h0};
    vecs[11] = '{0,0,12'h000,C1, 0,0,12'h000,V2, 0,0,12'h000,32'h0,0, 0,1,32'h0,32'h12345678};
    vecs[12] = '{0,0,12'h000,C1, 0,0,12'h000,V2, 0,0,12'h000,32'h0,0, 0,0,32'h0,32'h0};
    reset_pulse("init");
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 8; k++) begin
        vec_t v;
        v = '{1,0,12'h020,C1, 1,0,12'h030,V2, 0,1,12'h030,V2,0, 0,0,32'h0,32'h0};
        if (k == 1 && r == 1) begin v.ecrv = 1; v.ecq = 32'h160; end
        if (k > 1) begin v.evrv = 1; v.evq = 32'h190; end
        apply(v, $sformatf("starve r%0d c%0d", r, k));
      end
      apply('{1,0,12'h020,C1, 1,0,12'h030,V2, 1,0,12'h020,C1,0, 0,1,32'h0,32'h190},
            $sformatf("force r%0d", r));
    end
    apply('{0,0,12'h000,C1, 0,0,12'h000,V2, 0,0,12'h000,32'h0,0, 1,0,32'h160,32'h0}, "after force");
    apply('{1,0,12'h010,C1, 0,0,12'h000,V2, 1,0,12'h010,C1,0, 0,0,32'h0,32'h0}, "read before reset");
    #1;
    reset_pulse("mid read");
    apply('{0,0,12'h000,C1, 0,0,12'h000,V2, 0,0,12'h000,32'h0,0, 0,0,32'h0,32'h0}, "dropped rvalid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      drive(1, 0, 12'h020, C1, 1, 0, 12'h030, V2);
    end
    #2;
    reset_pulse("starve reset");
    begin
      int n = 0;
      logic got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clock);
        drive(1, 0, 12'h020, C1, 1, 0, 12'h030, V2);
        #2;
        if (cpu.gnt) got = 1;
        else if (cpu_stall) n++;
      end
      chk("force grant reached", 32'(got), 1);
      chk("stalls after reset", n, 8);
    end
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  always @(negedge clock) begin
    if (cpu.gnt && vga.gnt) begin
      fails++;
      $display("FAIL both grants: got cpu_gnt=1 vga_gnt=1 expected at most one");
    end
    if (cpu.rvalid && vga.rvalid) begin
      fails++;
      $display("FAIL both rvalids: got cpu_rvalid=1 vga_rvalid=1 expected at most one");
    end
  end
endmodule
